axis_video_rx_checker: RTL and testbench

AXI4-Stream video sink and checker for the 24-bit colour-bar test stream (start = start-of-frame, last = end-of-line). It sits at the consumer end of the test-pattern path, in place of the VGA/HDMI output stage. It does the following:
- accepts beats under a controllable ready;
- rebuilds pixel and line position;
- checks the framing and the three-bar colour pattern;
- reports sticky error flags and counters for bring-up on the PYNQ-Z2.

---
 rtl/video_pkg.sv | 18 +
 rtl/video_bar_ref.sv | 23 ++
 rtl/axis_video_rx_checker.sv | 136 +++++++++++++
 tb/tb_axis_video_rx_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the 720p colour-bar test-pattern path (generator and checker).
package video_pkg;

    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned BAR1_END_DEF  = 427;
    localparam int unsigned BAR2_END_DEF  = 853;

    localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;
    localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
    localparam logic [23:0] COLOR_RED   = 24'hFF0000;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } rx_state_e;

endpackage

// File: rtl/video_bar_ref.sv
// Combinational reference for the three-bar pattern: pixel column -> expected {R,G,B}.
module video_bar_ref
    import video_pkg::*;
#(
    parameter int unsigned XW       = 11,
    parameter int unsigned BAR1_END = BAR1_END_DEF,
    parameter int unsigned BAR2_END = BAR2_END_DEF
) (
    input  logic [XW-1:0] x_i,
    output logic [23:0]   color_o
);

    always_comb begin
        if (32'(x_i) < BAR1_END) begin
            color_o = COLOR_BLUE;
        end else if (32'(x_i) < BAR2_END) begin
            color_o = COLOR_GREEN;
        end else begin
            color_o = COLOR_RED;
        end
    end

endmodule

// File: rtl/axis_video_rx_checker.sv
// AXI4-Stream video sink: tracks pixel/line position, checks framing and the colour-bar
// pattern, and keeps sticky error flags plus frame/drop/error counters.
module axis_video_rx_checker
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_720P,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_720P,
    parameter int unsigned BAR1_END    = BAR1_END_DEF,
    parameter int unsigned BAR2_END    = BAR2_END_DEF,
    parameter bit          CHECK_COLOR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] i_data,
    input  logic        i_valid,
    input  logic        i_start,
    input  logic        i_last,
    output logic        o_ready,
    input  logic        i_stall,
    input  logic        i_err_clear,
    output logic        o_frame_done,
    output logic        o_err_sof,
    output logic        o_err_eol,
    output logic        o_err_pix,
    output logic [15:0] o_frame_count,
    output logic [15:0] o_drop_count,
    output logic [15:0] o_err_count
);

    localparam int unsigned   XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned   YW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    rx_state_e     state_q, state_d;
    logic [XW-1:0] x_q, x_d, pix_x;
    logic [YW-1:0] y_q, y_d, pix_y;
    logic [23:0]   exp_color;
    logic          xfer, take, drop, eol, frame_end;
    logic          set_sof, set_eol, set_pix;

    video_bar_ref #(
        .XW       (XW),
        .BAR1_END (BAR1_END),
        .BAR2_END (BAR2_END)
    ) u_bar_ref (
        .x_i     (pix_x),
        .color_o (exp_color)
    );

    assign xfer = i_valid & o_ready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        take      = 1'b0;
        drop      = 1'b0;
        set_sof   = 1'b0;
        set_eol   = 1'b0;
        set_pix   = 1'b0;
        frame_end = 1'b0;
        // A start beat always resynchronises to pixel (0,0) before anything else is judged.
        pix_x     = i_start ? '0 : x_q;
        pix_y     = i_start ? '0 : y_q;
        eol       = i_last | (pix_x == X_LAST);

        if (xfer) begin
            if (state_q == IN_FRAME || i_start) begin
                take = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        if (take) begin
            set_sof = (state_q == IN_FRAME) & i_start;
            // Early last, or missing last on the final column.
            set_eol = i_last ^ (pix_x == X_LAST);
            set_pix = CHECK_COLOR & (i_data != exp_color);
            if (eol) begin
                x_d = '0;
                if (pix_y == Y_LAST) begin
                    y_d       = '0;
                    state_d   = WAIT_SOF;
                    frame_end = 1'b1;
                end else begin
                    y_d     = pix_y + 1'b1;
                    state_d = IN_FRAME;
                end
            end else begin
                x_d     = pix_x + 1'b1;
                y_d     = pix_y;
                state_d = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= WAIT_SOF;
            x_q           <= '0;
            y_q           <= '0;
            o_ready       <= 1'b0;
            o_frame_done  <= 1'b0;
            o_err_sof     <= 1'b0;
            o_err_eol     <= 1'b0;
            o_err_pix     <= 1'b0;
            o_frame_count <= '0;
            o_drop_count  <= '0;
            o_err_count   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            o_ready      <= ~i_stall;
            o_frame_done <= frame_end;
            if (frame_end) begin
                o_frame_count <= o_frame_count + 16'd1;
            end
            if (drop && o_drop_count != 16'hFFFF) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
            // A flag raised on the clearing cycle survives the clear.
            o_err_sof <= (o_err_sof & ~i_err_clear) | set_sof;
            o_err_eol <= (o_err_eol & ~i_err_clear) | set_eol;
            o_err_pix <= (o_err_pix & ~i_err_clear) | set_pix;
            if (i_err_clear) begin
                o_err_count <= {15'd0, set_pix};
            end else if (set_pix && o_err_count != 16'hFFFF) begin
                o_err_count <= o_err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_video_rx_checker.sv
// Randomised bench for axis_video_rx_checker (8x4 frame, bars at 3/6) against a frame-level model.
module tb_axis_video_rx_checker;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int B1 = 3;
    localparam int B2 = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [23:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_start = 1'b0;
    logic        i_last = 1'b0;
    logic        o_ready;
    logic        i_stall = 1'b0;
    logic        i_err_clear = 1'b0;
    logic        o_frame_done, o_err_sof, o_err_eol, o_err_pix;
    logic [15:0] o_frame_count, o_drop_count, o_err_count;

    axis_video_rx_checker #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .BAR1_END    (B1),
        .BAR2_END    (B2),
        .CHECK_COLOR (1'b1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_start       (i_start),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .i_stall       (i_stall),
        .i_err_clear   (i_err_clear),
        .o_frame_done  (o_frame_done),
        .o_err_sof     (o_err_sof),
        .o_err_eol     (o_err_eol),
        .o_err_pix     (o_err_pix),
        .o_frame_count (o_frame_count),
        .o_drop_count  (o_drop_count),
        .o_err_count   (o_err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_pct = 0;
    int done_seen = 0;

    // Reference model: frame position plus expected output values.
    bit          m_in;
    int          m_x, m_y;
    bit          m_ready, m_done, m_sof, m_eol, m_pix;
    logic [15:0] m_frames;
    int          m_drops, m_errc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_color(input int x);
        if (x < B1) return 24'h0000FF;
        if (x < B2) return 24'h00FF00;
        return 24'hFF0000;
    endfunction

    task automatic model_reset();
        m_in = 0; m_x = 0; m_y = 0;
        m_ready = 0; m_done = 0; m_sof = 0; m_eol = 0; m_pix = 0;
        m_frames = 0; m_drops = 0; m_errc = 0;
    endtask

    task automatic model_edge(input bit took, input logic [23:0] d, input bit s, input bit l,
                              input bit clr);
        int px, py;
        bit line_end;
        m_done = 0;
        if (clr) begin
            m_sof = 0; m_eol = 0; m_pix = 0; m_errc = 0;
        end
        if (!took) return;
        if (!m_in && !s) begin
            if (m_drops < 65535) m_drops++;
            return;
        end
        px = s ? 0 : m_x;
        py = s ? 0 : m_y;
        if (m_in && s) m_sof = 1;
        if ((l && px < H - 1) || (!l && px == H - 1)) m_eol = 1;
        if (d != bar_color(px)) begin
            m_pix = 1;
            if (m_errc < 65535) m_errc++;
        end
        line_end = l || (px == H - 1);
        if (!line_end) begin
            m_x = px + 1; m_y = py; m_in = 1;
        end else if (py == V - 1) begin
            m_x = 0; m_y = 0; m_in = 0; m_done = 1; m_frames = m_frames + 16'd1;
        end else begin
            m_x = 0; m_y = py + 1; m_in = 1;
        end
    endtask

    task automatic compare_all();
        chk("ready", {31'd0, o_ready}, {31'd0, m_ready});
        chk("frame_done", {31'd0, o_frame_done}, {31'd0, m_done});
        chk("err_sof", {31'd0, o_err_sof}, {31'd0, m_sof});
        chk("err_eol", {31'd0, o_err_eol}, {31'd0, m_eol});
        chk("err_pix", {31'd0, o_err_pix}, {31'd0, m_pix});
        chk("frame_count", {16'd0, o_frame_count}, {16'd0, m_frames});
        chk("drop_count", {16'd0, o_drop_count}, 32'(m_drops));
        chk("err_count", {16'd0, o_err_count}, 32'(m_errc));
    endtask

    task automatic cycle(input bit v, input logic [23:0] d, input bit s, input bit l,
                         input bit clr, output bit took);
        bit stall;
        @(negedge clk);
        stall = ($urandom_range(0, 99) < stall_pct);
        i_valid = v; i_data = d; i_start = s; i_last = l;
        i_err_clear = clr; i_stall = stall;
        took = v && m_ready;
        @(posedge clk);
        #1;
        model_edge(took, d, s, l, clr);
        m_ready = !stall;
        if (o_frame_done) done_seen++;
        compare_all();
    endtask

    task automatic idle(input bit clr);
        bit took;
        cycle(1'b0, 24'h0, 1'b0, 1'b0, clr, took);
    endtask

    task automatic send_beat(input logic [23:0] d, input bit s, input bit l, input bit clr);
        bit took;
        int tries;
        took = 0;
        tries = 0;
        while (!took && tries < 200) begin
            cycle(1'b1, d, s, l, clr, took);
            tries++;
        end
        if (!took) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                send_beat(bar_color(x), x == 0 && y == 0, x == H - 1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        i_valid = 0; i_stall = 0; i_err_clear = 0; i_start = 0; i_last = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        m_ready = 1;
        chk("ready_after_reset", {31'd0, o_ready}, 32'd1);
        done_seen = 0;
    endtask

    initial begin
        bit s, l, good;
        int px;
        logic [23:0] d;

        #3;
        model_reset();
        do_reset();

        // Clean frame
        send_frame();
        idle(1'b0);
        chk("clean_done_pulses", 32'(done_seen), 32'd1);
        chk("clean_frames", {16'd0, o_frame_count}, 32'd1);
        chk("clean_flags", {29'd0, o_err_sof, o_err_eol, o_err_pix}, 32'd0);

        // Leading garbage
        do_reset();
        for (int i = 0; i < 5; i++) send_beat(bar_color(i), 1'b0, i == 4, 1'b0);
        send_frame();
        idle(1'b0);
        chk("garbage_drops", {16'd0, o_drop_count}, 32'd5);
        chk("garbage_frames", {16'd0, o_frame_count}, 32'd1);
        chk("garbage_flags", {29'd0, o_err_sof, o_err_eol, o_err_pix}, 32'd0);

        // Early last on line 1, x=5: 30 beats complete the frame
        do_reset();
        for (int x = 0; x < H; x++) send_beat(bar_color(x), x == 0, x == H - 1, 1'b0);
        for (int x = 0; x < 6; x++) send_beat(bar_color(x), 1'b0, x == 5, 1'b0);
        idle(1'b0);
        chk("eol_early_flag", {31'd0, o_err_eol}, 32'd1);
        for (int y = 2; y < V; y++)
            for (int x = 0; x < H; x++) send_beat(bar_color(x), 1'b0, x == H - 1, 1'b0);
        idle(1'b0);
        chk("eol_done_after_30", 32'(done_seen), 32'd1);

        // Mid-frame start at line 2, x=4, then 32 clean beats from (0,0)
        do_reset();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < H; x++) send_beat(bar_color(x), x == 0 && y == 0, x == H - 1, 1'b0);
        for (int x = 0; x < 4; x++) send_beat(bar_color(x), 1'b0, 1'b0, 1'b0);
        chk("sof_no_done_yet", 32'(done_seen), 32'd0);
        send_frame();
        idle(1'b0);
        chk("sof_flag", {31'd0, o_err_sof}, 32'd1);
        chk("sof_done", 32'(done_seen), 32'd1);

        // Colour error, then clear coinciding with a second bad pixel
        do_reset();
        for (int x = 0; x < 4; x++) send_beat(x == 3 ? 24'h0000FF : bar_color(x), x == 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("pix_flag", {31'd0, o_err_pix}, 32'd1);
        chk("pix_count", {16'd0, o_err_count}, 32'd1);
        send_beat(24'h123456, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("pix_clear_flag", {31'd0, o_err_pix}, 32'd1);
        chk("pix_clear_count", {16'd0, o_err_count}, 32'd1);

        // Reset mid-frame aborts; new beats without start are dropped
        do_reset();
        for (int x = 0; x < 5; x++) send_beat(bar_color(x), x == 0, 1'b0, 1'b0);
        do_reset();
        for (int x = 0; x < 3; x++) send_beat(bar_color(x), 1'b0, 1'b0, 1'b0);
        chk("reset_abort_drops", {16'd0, o_drop_count}, 32'd3);

        // Backpressure with idle gaps
        do_reset();
        stall_pct = 50;
        for (int f = 0; f < 3; f++) begin
            send_frame();
            repeat ($urandom_range(0, 3)) idle(1'b0);
        end
        idle(1'b0);
        chk("bp_frames", {16'd0, o_frame_count}, 32'd3);
        chk("bp_done_pulses", 32'(done_seen), 32'd3);
        chk("bp_flags", {29'd0, o_err_sof, o_err_eol, o_err_pix}, 32'd0);

        // Random framing and colour faults
        do_reset();
        stall_pct = 30;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 11) == 0);
            px = s ? 0 : m_x;
            l = (px == H - 1) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 15) == 0);
            good = ($urandom_range(0, 9) != 0);
            d = good ? bar_color(px) : 24'($urandom);
            send_beat(d, s, l, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) idle(1'b0);
        end
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
